// File: rtl/logic_oracle_responder.sv
// Synthesizable logic-oracle responder: answers CPU requests from a loadable
// result table after a programmable latency and keeps hit/miss/abort statistics.
module logic_oracle_responder #(
  parameter int          TABLE_DEPTH  = 16,
  parameter logic [31:0] DEFAULT_DATA = 32'hABCD1234,
  parameter int          CNT_W        = 16,
  localparam int         IDX_W        = $clog2(TABLE_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             logic_req,
  input  logic [31:0]      logic_addr,
  output logic             logic_ack,
  output logic [31:0]      logic_data,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic             cfg_clear,
  input  logic [7:0]       cfg_latency,
  output logic             busy,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] abort_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  state_t                 r_state;
  logic [31:0]            r_table [TABLE_DEPTH];
  logic [TABLE_DEPTH-1:0] r_valid;
  logic [7:0]             r_cnt;
  logic [31:0]            r_result;
  logic                   r_is_hit;
  logic                   r_ack;
  logic [31:0]            r_data;
  logic [CNT_W-1:0]       r_hit_cnt, r_miss_cnt, r_abort_cnt;

  logic [IDX_W-1:0]       w_idx;
  logic                   w_hit;
  logic [TABLE_DEPTH-1:0] w_valid_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_idx = logic_addr[IDX_W+1:2];
  assign w_hit = (logic_addr[31:IDX_W+2] == '0) && (logic_addr[1:0] == 2'b00) && r_valid[w_idx];

  // Clear first, then a same-cycle write re-validates its own entry.
  always_comb begin
    w_valid_nxt = cfg_clear ? '0 : r_valid;
    if (cfg_we) w_valid_nxt[cfg_addr] = 1'b1;
  end

  // Table data is deliberately left out of reset; only valid bits clear.
  always_ff @(posedge clk) begin
    if (cfg_we) r_table[cfg_addr] <= cfg_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_valid <= '0;
    else        r_valid <= w_valid_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_result    <= '0;
      r_is_hit    <= 1'b0;
      r_ack       <= 1'b0;
      r_data      <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_abort_cnt <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Capture uses pre-write table/valid contents (read-before-write).
          if (logic_req) begin
            r_result <= w_hit ? r_table[w_idx] : DEFAULT_DATA;
            r_is_hit <= w_hit;
            r_cnt    <= cfg_latency;
            r_state  <= (cfg_latency == 8'd0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          if (!logic_req) begin
            r_state     <= S_IDLE;
            r_abort_cnt <= sat_inc(r_abort_cnt);
          end else if (r_cnt == 8'd1) begin
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_ack   <= 1'b1;
          r_data  <= r_result;
          r_state <= S_HOLD;
          if (r_is_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
          else          r_miss_cnt <= sat_inc(r_miss_cnt);
        end
        S_HOLD: begin
          if (!logic_req) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign logic_ack   = r_ack;
  assign logic_data  = r_data;
  assign busy        = (r_state != S_IDLE);
  assign hit_count   = r_hit_cnt;
  assign miss_count  = r_miss_cnt;
  assign abort_count = r_abort_cnt;

endmodule

// File: tb/tb_logic_oracle_responder.sv
// Directed bench for logic_oracle_responder; counters narrowed to 4 bits so
// saturation is reachable in a short run.
module tb_logic_oracle_responder;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        logic_req;
  logic [31:0] logic_addr;
  logic        logic_ack;
  logic [31:0] logic_data;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_clear;
  logic [7:0]  cfg_latency;
  logic        busy;
  logic [CW-1:0] hit_count, miss_count, abort_count;

  int n_pass = 0;
  int n_chk  = 0;
  int n;
  int acks;
  logic [31:0] d;

  logic_oracle_responder #(.TABLE_DEPTH(16), .DEFAULT_DATA(32'hABCD1234), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .logic_req(logic_req), .logic_addr(logic_addr),
    .logic_ack(logic_ack), .logic_data(logic_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_clear(cfg_clear), .cfg_latency(cfg_latency), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count), .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Counts ticks (continuing from start) until ack, bounded at 40.
  task automatic wait_ack(input int start, output int cnt);
    cnt = start;
    do begin tick(); cnt++; end while (!logic_ack && cnt < 40);
  endtask

  task automatic req_ack(input logic [31:0] addr, input int exp_n, output logic [31:0] data);
    int k;
    logic_addr = addr;
    logic_req  = 1'b1;
    wait_ack(0, k);
    chk("ack_latency", k, exp_n);
    data = logic_data;
    logic_req = 1'b0;
    tick();
    chk("ack_one_cycle", {31'd0, logic_ack}, 32'd0);
    chk("idle_after_drop", {31'd0, busy}, 32'd0);
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [31:0] val);
    cfg_we = 1'b1; cfg_addr = idx; cfg_wdata = val;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; logic_req = 1'b0; logic_addr = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_wdata = '0; cfg_clear = 1'b0; cfg_latency = '0;
    tick(); tick();
    // 1: reset state, load, latency 0 hit
    chk("rst_ack", {31'd0, logic_ack}, 32'd0);
    chk("rst_data", logic_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnts", {hit_count, miss_count, abort_count}, 32'd0);
    rst_n = 1'b1;
    cfg_write(4'd3, 32'h0000BEEF);
    req_ack(32'h0C, 2, d);
    chk("t1_data", d, 32'h0000BEEF);
    chk("t1_hit", hit_count, 32'd1);

    // 2: misses with latency 3
    cfg_latency = 8'd3;
    req_ack(32'h100, 5, d);
    chk("t2_oob_data", d, 32'hABCD1234);
    chk("t2_miss1", miss_count, 32'd1);
    req_ack(32'h0E, 5, d);
    chk("t2_misalign_data", d, 32'hABCD1234);
    chk("t2_miss2", miss_count, 32'd2);

    // 3: abort during WAIT
    cfg_latency = 8'd5;
    logic_addr = 32'h0C; logic_req = 1'b1;
    tick(); tick();
    logic_req = 1'b0;
    tick();
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_abort", abort_count, 32'd1);
    acks = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (logic_ack) acks++; end
    chk("t3_no_ack", acks, 32'd0);
    chk("t3_data_held", logic_data, 32'hABCD1234);
    chk("t3_hit_unch", hit_count, 32'd1);

    // 4: held request acked once; re-request after a low cycle
    cfg_latency = 8'd0;
    logic_addr = 32'h0C; logic_req = 1'b1;
    wait_ack(0, n);
    chk("t4_lat", n, 32'd2);
    acks = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (logic_ack) acks++; end
    chk("t4_single_ack", acks, 32'd0);
    chk("t4_hold_busy", {31'd0, busy}, 32'd1);
    logic_req = 1'b0;
    tick();
    req_ack(32'h0C, 2, d);
    chk("t4_hit", hit_count, 32'd3);
    // latency sampled only at latch
    cfg_latency = 8'd2;
    logic_addr = 32'h0C; logic_req = 1'b1;
    tick();
    cfg_latency = 8'd0;
    wait_ack(1, n);
    chk("t4_lat_sampled", n, 32'd4);
    logic_req = 1'b0;
    tick();
    chk("t4_hit2", hit_count, 32'd4);

    // 5: read-before-write collision, clear, clear+write
    cfg_write(4'd2, 32'h11111111);
    logic_addr = 32'h08; logic_req = 1'b1;
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 32'h22222222;
    tick();
    cfg_we = 1'b0;
    wait_ack(1, n);
    chk("t5_coll_lat", n, 32'd2);
    chk("t5_coll_old", logic_data, 32'h11111111);
    logic_req = 1'b0;
    tick();
    req_ack(32'h08, 2, d);
    chk("t5_new", d, 32'h22222222);
    chk("t5_hit", hit_count, 32'd6);
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    req_ack(32'h08, 2, d);
    chk("t5_cleared", d, 32'hABCD1234);
    chk("t5_miss", miss_count, 32'd3);
    cfg_clear = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 32'h33333333;
    tick();
    cfg_clear = 1'b0; cfg_we = 1'b0;
    req_ack(32'h08, 2, d);
    chk("t5_clr_wr_hit", d, 32'h33333333);
    req_ack(32'h0C, 2, d);
    chk("t5_clr_other", d, 32'hABCD1234);
    chk("t5_counts", {hit_count, miss_count}, {24'd0, 4'd7, 4'd4});

    // 6: reset mid-request, then miss counter saturation
    cfg_latency = 8'd4;
    logic_addr = 32'h0C; logic_req = 1'b1;
    tick(); tick();
    chk("t6_wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    logic_req = 1'b0;
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (logic_ack) acks++; end
    chk("t6_no_ack", acks, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_cnts", {hit_count, miss_count, abort_count}, 32'd0);
    chk("t6_data", logic_data, 32'd0);
    cfg_latency = 8'd0;
    for (int i = 0; i < 15; i++) req_ack(32'h100, 2, d);
    chk("t6_miss_full", miss_count, 32'hF);
    req_ack(32'h100, 2, d);
    req_ack(32'h100, 2, d);
    chk("t6_miss_sat", miss_count, 32'hF);
    chk("t6_hit_zero", hit_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
